dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter for the shared 256 x 19-bit data memory. Requester A is the pipeline MEM stage; requester B is the debug/loader port. The arbiter issues at most one memory command per cycle and returns read data to the winning port one cycle later. Fixed priority favours A, but a starvation counter guarantees B progress.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 19, memory data width
- STARVE_LIMIT, 4, consecutive B losses before B is forced to win; legal range 1..15
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- a_req  in  1  A requests an access; held with its fields until a_gnt
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A command issued this cycle (combinational)
- a_stall  out  1  a_req & ~a_gnt; drives pipeline stall
- a_rvalid  out  1  A read data valid
- a_rdata  out  DATA_W  A read data
- b_req, b_we, b_addr, b_wdata  in  1/1/ADDR_W/DATA_W  same meaning for B
- b_gnt, b_rvalid  out  1  same meaning for B
- b_rdata  out  DATA_W  B read data
- mem_memread  out  1  memory read strobe
- mem_memwrite  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; registered by the memory at the issue edge

## Operation
- Priority state machine, two states:
  - PRI_A (reset state): A wins if a_req; otherwise B wins if b_req.
  - PRI_B: B wins if b_req; otherwise A wins if a_req.
- Transitions:
  - PRI_A -> PRI_B when starve_cnt == STARVE_LIMIT-1, a_req & b_req, and A is granted.
  - PRI_B -> PRI_A on any B grant, or when b_req is low.
- starve_cnt (4 bits) behaviour:
  - Increments when a_req & b_req & a_gnt.
  - Clears on b_gnt, on ~b_req, or on entry to PRI_B.
  - Never exceeds STARVE_LIMIT-1.
- Issue: the winner's we/addr/wdata drive the mem_* outputs in the same cycle.
  - mem_memread = gnt & ~we; mem_memwrite = gnt & we.
  - The two strobes are never both 1.
  - With no grant: strobes are 0, and mem_addr/mem_wdata hold their last value.
- Response tracking:
  - A registered pair (rpend, rsel) is set on the edge where a read is issued, recording the winner.
  - rpend clears on the next edge unless another read issues.
- Read data: a_rdata = b_rdata = mem_rdata (broadcast). a_rvalid = rpend & ~rsel; b_rvalid = rpend & rsel.
- Writes produce no rvalid. Completion is the grant cycle.
- Back-to-back reads from either or both ports are supported at one per cycle; responses return in issue order.
- A request must not be withdrawn or changed before its grant. If it is, behaviour is not specified and no check is required.

## Timing
- Grant latency: 0 cycles (combinational from req and state). Read data latency: rvalid exactly 1 cycle after the grant cycle.
- Throughput: one access per cycle. Under continuous contention B receives 1 grant per STARVE_LIMIT+1 cycles.
- Reset asserted, asynchronous:
  - state = PRI_A, starve_cnt = 0, rpend = 0, rsel = 0.
  - a_gnt, b_gnt, a_stall, b_stall-equivalent, mem_memread, mem_memwrite, a_rvalid, b_rvalid all forced to 0 while reset is low.
  - mem_addr and mem_wdata are 0.
- Reset mid-operation: an outstanding read response is dropped (no rvalid after release). The first grant is possible in the first cycle with reset high.
- Simultaneous requests in PRI_A with starve_cnt < STARVE_LIMIT-1: A wins, a_stall = 0, b_gnt = 0.
- STARVE_LIMIT = 1: B wins every second contended cycle (strict alternation).

## Test plan
- Reset release, A read at addr 0x10 (memory model preloaded with 0x1234) -> a_gnt=1 same cycle, mem_memread=1, mem_addr=0x10; next cycle a_rvalid=1, a_rdata=0x1234, b_rvalid=0.
- B writes 0x7FFFF to 0xFF, then B reads 0xFF -> mem_memwrite=1 in cycle 1 with no rvalid; b_rvalid=1 with b_rdata=0x7FFFF in cycle 3.
- a_req and b_req held high for 15 cycles, STARVE_LIMIT=4 -> grant pattern A,A,A,A,B repeated 3 times; mem strobes never both high; a_stall high exactly in the B cycles.
- Interleaved reads, A at 0x01 then B at 0x02 on consecutive cycles -> a_rvalid, then b_rvalid, on consecutive cycles with the correct data; no overlap.
- reset pulled low the cycle after an A read is issued -> a_rvalid stays 0; all outputs 0 during reset; after release the first A request is granted immediately.
- STARVE_LIMIT=1 with both ports requesting -> strict A,B,A,B alternation; starve_cnt never exceeds 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port.
// The arbiter uses the slave modport; requesters and memory use master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 19
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_stall;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_memread;
  logic              mem_memwrite;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_stall, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_memread, mem_memwrite, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_stall, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_memread, mem_memwrite, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared data memory: fixed priority to A with a
// starvation counter that forces a B win after STARVE_LIMIT contended losses.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 19,
  parameter int STARVE_LIMIT = 4
) (
  input logic            i_clk,
  input logic            i_rst_n,
  dmem_arbiter_if.slave  io_bus
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  pri_e              r_state;
  logic [3:0]        r_starve;
  logic              r_rpend;
  logic              r_rsel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_any_gnt;
  logic              w_contend;
  logic              w_we;
  logic              w_rd_issue;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Grants are gated by reset so nothing issues while reset is held low.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (i_rst_n) begin
      if (r_state == PRI_A) begin
        w_a_gnt = io_bus.a_req;
        w_b_gnt = io_bus.b_req & ~io_bus.a_req;
      end else begin
        w_b_gnt = io_bus.b_req;
        w_a_gnt = io_bus.a_req & ~io_bus.b_req;
      end
    end
  end

  assign w_any_gnt  = w_a_gnt | w_b_gnt;
  assign w_contend  = io_bus.a_req & io_bus.b_req;
  assign w_we       = w_b_gnt ? io_bus.b_we    : io_bus.a_we;
  assign w_addr     = w_b_gnt ? io_bus.b_addr  : io_bus.a_addr;
  assign w_wdata    = w_b_gnt ? io_bus.b_wdata : io_bus.a_wdata;
  assign w_rd_issue = w_any_gnt & ~w_we;

  assign io_bus.a_gnt        = w_a_gnt;
  assign io_bus.b_gnt        = w_b_gnt;
  assign io_bus.a_stall      = i_rst_n & io_bus.a_req & ~w_a_gnt;
  assign io_bus.mem_memread  = w_any_gnt & ~w_we;
  assign io_bus.mem_memwrite = w_any_gnt & w_we;
  // Address and data hold the last issued command when idle.
  assign io_bus.mem_addr     = w_any_gnt ? w_addr  : r_addr;
  assign io_bus.mem_wdata    = w_any_gnt ? w_wdata : r_wdata;

  assign io_bus.a_rdata  = io_bus.mem_rdata;
  assign io_bus.b_rdata  = io_bus.mem_rdata;
  assign io_bus.a_rvalid = r_rpend & ~r_rsel;
  assign io_bus.b_rvalid = r_rpend & r_rsel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= PRI_A;
      r_starve <= 4'd0;
      r_rpend  <= 1'b0;
      r_rsel   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_rpend <= w_rd_issue;
      if (w_rd_issue) begin
        r_rsel <= w_b_gnt;
      end
      if (w_any_gnt) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      case (r_state)
        PRI_A: begin
          if (w_contend & w_a_gnt & (r_starve == LIMIT_M1)) begin
            r_state  <= PRI_B;
            r_starve <= 4'd0;
          end else if (w_b_gnt | ~io_bus.b_req) begin
            r_starve <= 4'd0;
          end else if (w_contend & w_a_gnt) begin
            r_starve <= r_starve + 4'd1;
          end
        end
        PRI_B: begin
          // B holds its request until granted, so this state lasts one cycle.
          if (w_b_gnt | ~io_bus.b_req) begin
            r_state <= PRI_A;
          end
          r_starve <= 4'd0;
        end
        default: begin
          r_state  <= PRI_A;
          r_starve <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter with a behavioural
// arbitration model and a read-response scoreboard.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(19)) bus ();
  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(19)) bus1 ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(19), .STARVE_LIMIT(LIMIT)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus)
  );
  dmem_arbiter #(.ADDR_W(8), .DATA_W(19), .STARVE_LIMIT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus1)
  );

  typedef struct packed {
    logic        port;
    logic [18:0] data;
  } exp_t;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  logic [18:0] ref_mem [256];
  logic [18:0] env_mem [256];
  bit written [256];
  int losses = 0;
  logic [7:0]  last_addr = '0;
  logic [18:0] last_wdata = '0;
  bit a_won = 0;
  bit b_won = 0;

  function automatic logic [18:0] init_val(input logic [7:0] a);
    logic [31:0] v;
    v = 32'(a) * 32'd40503 + 32'd977;
    return (a == 8'h10) ? 19'h01234 : v[18:0];
  endfunction

  function automatic logic [7:0] rnd_addr();
    return ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory environment: registers read data at the issue edge.
  always @(posedge clk) begin
    if (bus.mem_memread)
      bus.mem_rdata <= written[bus.mem_addr] ? env_mem[bus.mem_addr] : init_val(bus.mem_addr);
    if (bus.mem_memwrite) begin
      env_mem[bus.mem_addr] <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
  end

  // Monitor: every issued read must answer exactly one cycle later.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("a_rvalid", bus.a_rvalid, !e.port);
      chk("b_rvalid", bus.b_rvalid, e.port);
      chk("rdata", e.port ? bus.b_rdata : bus.a_rdata, e.data);
      $display("read resp port=%s data=%0h", e.port ? "B" : "A", e.data);
    end else begin
      chk("no_rvalid", {bus.a_rvalid, bus.b_rvalid}, 0);
    end
  end

  // Called just after inputs change at the falling edge.
  task automatic step();
    bit ea, eb, we;
    logic [7:0]  ad;
    logic [18:0] wd;
    #1;
    if (bus.a_req && bus.b_req) begin
      eb = (losses == LIMIT);
      ea = !eb;
    end else begin
      ea = bus.a_req;
      eb = bus.b_req;
    end
    chk("a_gnt", bus.a_gnt, ea);
    chk("b_gnt", bus.b_gnt, eb);
    chk("a_stall", bus.a_stall, bus.a_req && !ea);
    chk("strobe_excl", bus.mem_memread & bus.mem_memwrite, 0);
    if (ea || eb) begin
      we = eb ? bus.b_we : bus.a_we;
      ad = eb ? bus.b_addr : bus.a_addr;
      wd = eb ? bus.b_wdata : bus.a_wdata;
      chk("mem_memread", bus.mem_memread, !we);
      chk("mem_memwrite", bus.mem_memwrite, we);
      chk("mem_addr", bus.mem_addr, ad);
      chk("mem_wdata", bus.mem_wdata, wd);
      if (we) ref_mem[ad] = wd;
      else exp_q.push_back('{port: eb, data: ref_mem[ad]});
      last_addr = ad;
      last_wdata = wd;
      $display("issue port=%s we=%0d addr=%0h wdata=%0h", eb ? "B" : "A", we, ad, wd);
    end else begin
      chk("idle_strobes", {bus.mem_memread, bus.mem_memwrite}, 0);
      chk("mem_addr_hold", bus.mem_addr, last_addr);
      chk("mem_wdata_hold", bus.mem_wdata, last_wdata);
    end
    if (!bus.b_req || eb) losses = 0;
    else if (bus.a_req) losses++;
    a_won = ea;
    b_won = eb;
  endtask

  task automatic set_a(input bit rq, input bit we, input logic [7:0] ad, input logic [18:0] wd);
    bus.a_req = rq; bus.a_we = we; bus.a_addr = ad; bus.a_wdata = wd;
  endtask

  task automatic set_b(input bit rq, input bit we, input logic [7:0] ad, input logic [18:0] wd);
    bus.b_req = rq; bus.b_we = we; bus.b_addr = ad; bus.b_wdata = wd;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_gnt"}, bus.a_gnt, 0);
    chk({tag, "_b_gnt"}, bus.b_gnt, 0);
    chk({tag, "_a_stall"}, bus.a_stall, 0);
    chk({tag, "_strobes"}, {bus.mem_memread, bus.mem_memwrite}, 0);
    chk({tag, "_rvalid"}, {bus.a_rvalid, bus.b_rvalid}, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    $display("reset check %s", tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = 0; bus1.a_wdata = 0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = 0; bus1.b_wdata = 0;
    bus1.mem_rdata = 0;
    bus.mem_rdata = 0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    set_a(1, 1, 8'h55, 19'h1);
    set_b(1, 0, 8'h66, 19'h2);
    #1 check_reset_outputs("init");
    @(negedge clk);
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    // A read of a preloaded word right after reset release
    @(negedge clk); set_a(1, 0, 8'h10, 19'h0); step();
    @(negedge clk); set_a(0, 0, 0, 0); step();

    // B write of the maximum value, then read back
    @(negedge clk); set_b(1, 1, 8'hFF, 19'h7FFFF); step();
    @(negedge clk); set_b(1, 0, 8'hFF, 19'h0); step();
    @(negedge clk); set_b(0, 0, 0, 0); step();

    // Back-to-back reads from alternating ports
    @(negedge clk); set_a(1, 0, 8'h01, 19'h0); step();
    @(negedge clk); set_a(0, 0, 0, 0); set_b(1, 0, 8'h02, 19'h0); step();
    @(negedge clk); set_b(0, 0, 0, 0); step();
    @(negedge clk); step();

    // Continuous contention: A,A,A,A,B repeating
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0 || a_won) set_a(1, 0, rnd_addr(), 19'($urandom));
      if (i == 0 || b_won) set_b(1, 0, rnd_addr(), 19'($urandom));
      step();
      chk("pattern_b", bus.b_gnt, (i % 5 == 4));
    end
    @(negedge clk); set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); step();
    @(negedge clk); step();

    // Reset asserted the cycle after an A read issues
    @(negedge clk); set_a(1, 0, 8'h20, 19'h0); step();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    losses = 0;
    last_addr = '0;
    last_wdata = '0;
    @(negedge clk);
    set_a(1, 1, 8'h33, 19'h4444);
    set_b(1, 0, 8'h34, 19'h0);
    #1 check_reset_outputs("mid");
    @(negedge clk);
    #1 check_reset_outputs("mid2");
    @(negedge clk);
    rst_n = 1'b1;
    set_b(0, 0, 0, 0);
    step();
    chk("first_gnt_after_reset", bus.a_gnt, 1);

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (a_won) bus.a_req = 0;
      if (b_won) bus.b_req = 0;
      if (!bus.a_req && ($urandom % 3 != 0)) set_a(1, 1'($urandom), rnd_addr(), 19'($urandom));
      if (!bus.b_req && ($urandom % 2 != 0)) set_b(1, 1'($urandom), rnd_addr(), 19'($urandom));
      step();
    end
    @(negedge clk); set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); step();
    @(negedge clk); step();
    @(negedge clk); step();
    chk("queue_drained", exp_q.size(), 0);

    // Limit of one: strict alternation on the second instance
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus1.a_req = 1; bus1.b_req = 1;
      bus1.a_addr = 8'(i); bus1.b_addr = 8'(i + 100);
      #1;
      chk("alt_a_gnt", bus1.a_gnt, (i % 2 == 0));
      chk("alt_b_gnt", bus1.b_gnt, (i % 2 == 1));
      chk("alt_a_stall", bus1.a_stall, (i % 2 == 1));
      $display("alt cycle %0d a_gnt=%0d b_gnt=%0d", i, bus1.a_gnt, bus1.b_gnt);
    end
    @(negedge clk);
    bus1.a_req = 0; bus1.b_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
